alu_arbiter_8: RTL and testbench
================================

# alu_arbiter_8

Shares one 8-bit ALU datapath between two requesters. Each operation is accepted through a valid/ready handshake, executed in one registered cycle and returned with flags and a requester tag. Grants are round-robin. The block sits between the instruction/control logic of the 8-bit ALU and the bitwise/arithmetic datapath, and is the only path into that datapath.

## Interface
Parameters:
- W, 8, datapath width. Only 8 is supported; it exists for readability.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  3  requester 0 opcode
- req0_a, req0_b  in  8  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_out  out  8  result
- res_id  out  1  requester that issued the result
- res_carry  out  1  carry/borrow/shift-out flag
- res_zero  out  1  res_out == 0

## Operation
- FSM with three states: IDLE, EXEC, DONE.
- IDLE:
  - Grant: if exactly one reqN_valid is high, grant N. If both are high, grant the requester that is not last_grant.
  - reqN_ready = (state==IDLE) && !rst && grant==N. At most one ready is high per cycle. Ready may depend on valid.
  - On handshake (valid && ready), latch op/a/b into operand registers and id into cur_id, then go to EXEC.
- EXEC: compute from the latched operands, register res_out/res_carry/res_zero/res_id, set res_valid, then go to DONE.
- DONE: hold res_valid=1 and all res_* stable. On res_ready=1, clear res_valid, set last_grant=cur_id and go to IDLE.
- Opcodes. Results are 8-bit, truncated. Carry is 0 unless stated.
  - 000 AND a&b
  - 001 OR a|b
  - 010 XOR a^b
  - 011 ADD a+b; carry = bit 8 of the 9-bit sum
  - 100 SUB a-b (two's complement); carry = 1 when a>=b (no borrow)
  - 101 NOT ~a (b ignored)
  - 110 SHL {a[6:0],0}; carry = a[7]
  - 111 SHR {0,a[7:1]} logical; carry = a[0]
- res_zero is computed from the 8-bit result for every opcode.
- Requesters hold valid/op/a/b stable until their handshake. Dropping valid before ready is legal; that request is simply not taken.
- Reset values: state=IDLE, res_valid=0, res_out=0x00, res_id=0, res_carry=0, res_zero=0, last_grant=1 (requester 0 wins first contention), operand registers=0. Both ready outputs are 0 while rst=1.

## Timing
- Handshake in cycle N gives res_valid=1 from cycle N+2. Latency is 2 cycles.
- Peak throughput is one operation per 3 cycles: DONE release in cycle M, next accept no earlier than M+1.
- No request is accepted in EXEC or DONE: both ready outputs are 0 regardless of valid.
- Backpressure: res_ready low in DONE holds the state indefinitely with outputs unchanged.
- Grant uses last_grant, which only updates on result release. A requester that stays valid is therefore granted within 2 operations (no starvation).
- Simultaneous events:
  - res_ready high in DONE while both valid: the return to IDLE happens first, and the new accept occurs the next cycle per updated last_grant.
  - res_ready high outside DONE is ignored.
- Reset mid-operation (EXEC or DONE): the in-flight operation is discarded and no result is produced. The next cycle shows reset values, and last_grant returns to 1.

## Test plan
- req0 only, op=000, a=0xF0, b=0x3C, res_ready=1: handshake in cycle N gives res_valid in N+2 with res_out=0x30, id=0, carry=0, zero=0. res_valid drops in N+3.
- req1 ADD a=0xFF, b=0x01 → res_out=0x00, carry=1, zero=1, id=1. Then ADD 0x7F+0x01 → 0x80, carry=0, zero=0.
- SUB 0x05−0x07 → 0xFE, carry=0. SUB 0x07−0x05 → 0x02, carry=1. SHL 0x81 → 0x02, carry=1. SHR 0x01 → 0x00, carry=1, zero=1. NOT 0xA5 → 0x5A.
- Both requesters continuously valid from reset release: res_id sequence is 0,1,0,1. Each requester's ready pulses exactly once per 3 cycles at most, and the two readies are never high together.
- Backpressure: after result appears, hold res_ready=0 for 5 cycles with both valid. res_* stay constant, both ready outputs stay 0, and exactly one new accept follows the release.
- Assert rst for one cycle during EXEC of req1 XOR 0xFF^0x0F. No result is produced and outputs return to reset values. With both valid afterwards, requester 0 is granted first.

Source files
------------

// File: rtl/alu_arbiter_8.sv
// Two-requester front end for the 8-bit ALU datapath: round-robin grant,
// one registered execute cycle, and a held result with flags and requester tag.
module alu_arbiter_8 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_out,
    output logic         res_id,
    output logic         res_carry,
    output logic         res_zero
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t       state;
    logic         last_grant;
    logic         cur_id;
    logic [2:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;

    logic [W-1:0] alu_out;
    logic         alu_carry;
    logic [W:0]   sum;

    // Under contention the requester that was not served last wins.
    always_comb begin
        req0_ready = (state == IDLE) && !rst && req0_valid &&
                     (!req1_valid || last_grant);
        req1_ready = (state == IDLE) && !rst && req1_valid &&
                     (!req0_valid || !last_grant);
    end

    always_comb begin
        sum       = {1'b0, a_q} + {1'b0, b_q};
        alu_out   = '0;
        alu_carry = 1'b0;
        case (op_q)
            3'b000: alu_out = a_q & b_q;
            3'b001: alu_out = a_q | b_q;
            3'b010: alu_out = a_q ^ b_q;
            3'b011: begin
                alu_out   = sum[W-1:0];
                alu_carry = sum[W];
            end
            3'b100: begin
                alu_out   = a_q - b_q;
                alu_carry = (a_q >= b_q);
            end
            3'b101: alu_out = ~a_q;
            3'b110: begin
                alu_out   = {a_q[W-2:0], 1'b0};
                alu_carry = a_q[W-1];
            end
            3'b111: begin
                alu_out   = {1'b0, a_q[W-1:1]};
                alu_carry = a_q[0];
            end
            default: alu_out = '0;
        endcase
    end

    // last_grant moves only on result release, so a waiting requester is
    // served within two operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_valid  <= 1'b0;
            res_out    <= '0;
            res_id     <= 1'b0;
            res_carry  <= 1'b0;
            res_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        op_q   <= req0_op;
                        a_q    <= req0_a;
                        b_q    <= req0_b;
                        cur_id <= 1'b0;
                        state  <= EXEC;
                    end else if (req1_ready) begin
                        op_q   <= req1_op;
                        a_q    <= req1_a;
                        b_q    <= req1_b;
                        cur_id <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_out   <= alu_out;
                    res_carry <= alu_carry;
                    res_zero  <= (alu_out == '0);
                    res_id    <= cur_id;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        last_grant <= cur_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter_8.sv
// Directed bench for alu_arbiter_8: opcode vector table plus hand-written
// arbitration, backpressure and mid-operation reset sequences.
module tb_alu_arbiter_8;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [2:0] req0_op;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [2:0] req1_op;
    logic [7:0] req1_a, req1_b;
    logic       res_valid, res_ready;
    logic [7:0] res_out;
    logic       res_id, res_carry, res_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_out;
        logic       exp_carry;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[10];

    alu_arbiter_8 #(.W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
        .res_id(res_id), .res_carry(res_carry), .res_zero(res_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
        end
    endtask

    // Drive one requester and wait (bounded) until its ready is seen; the
    // handshake then happens on the next rising edge.
    task automatic applyStimulus(input logic id, input logic [2:0] op,
                                 input logic [7:0] a, input logic [7:0] b,
                                 output bit accepted);
        @(negedge clk);
        res_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        accepted = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got no ready for requester %0d expected ready", id);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic runVector(input vec_t v, input int idx);
        bit acc;
        applyStimulus(v.id, v.op, v.a, v.b, acc);
        if (acc) begin
            checkOutput($sformatf("v%0d_other_ready", idx),
                        8'(v.id ? req0_ready : req1_ready), 8'd0);
            @(posedge clk);
            @(negedge clk);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            #1;
            checkOutput($sformatf("v%0d_valid_n1", idx), 8'(res_valid), 8'd0);
            @(negedge clk);
            #1;
            checkOutput($sformatf("v%0d_valid_n2", idx), 8'(res_valid), 8'd1);
            checkOutput($sformatf("v%0d_out", idx), res_out, v.exp_out);
            checkOutput($sformatf("v%0d_carry", idx), 8'(res_carry), 8'(v.exp_carry));
            checkOutput($sformatf("v%0d_zero", idx), 8'(res_zero), 8'(v.exp_zero));
            checkOutput($sformatf("v%0d_id", idx), 8'(res_id), 8'(v.id));
            @(negedge clk);
            #1;
            checkOutput($sformatf("v%0d_valid_n3", idx), 8'(res_valid), 8'd0);
        end
    endtask

    initial begin
        bit        acc;
        int        cyc;
        int        accepts;
        bit        seen;
        int        accept_cycles[$];
        logic      ids[$];

        vecs[0] = '{1'b0, 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 3'b011, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 3'b011, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 3'b100, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 3'b100, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 3'b110, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 3'b111, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 3'b101, 8'hA5, 8'h33, 8'h5A, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 3'b001, 8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 3'b010, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};

        // Reset with both requesters valid: readies must stay low.
        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 8'h00; req1_b = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ready0", 8'(req0_ready), 8'd0);
        checkOutput("rst_ready1", 8'(req1_ready), 8'd0);
        checkOutput("rst_valid", 8'(res_valid), 8'd0);
        checkOutput("rst_out", res_out, 8'h00);
        checkOutput("rst_id", 8'(res_id), 8'd0);
        checkOutput("rst_carry", 8'(res_carry), 8'd0);
        checkOutput("rst_zero", 8'(res_zero), 8'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) runVector(vecs[i], i);

        // Both requesters valid straight out of reset: strict alternation.
        @(negedge clk);
        rst = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 8'h11; req0_b = 8'h22;
        req1_valid = 1'b1; req1_op = 3'b001; req1_a = 8'h44; req1_b = 8'h88;
        @(negedge clk);
        rst = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            #1;
            checkOutput("rr_both_ready", 8'(req0_ready && req1_ready), 8'd0);
            if (req0_ready || req1_ready) accept_cycles.push_back(cyc);
            if (res_valid) ids.push_back(res_id);
            if (ids.size() == 4) break;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checkOutput("rr_result_count", 8'(ids.size()), 8'd4);
        if (ids.size() == 4) begin
            checkOutput("rr_id0", 8'(ids[0]), 8'd0);
            checkOutput("rr_id1", 8'(ids[1]), 8'd1);
            checkOutput("rr_id2", 8'(ids[2]), 8'd0);
            checkOutput("rr_id3", 8'(ids[3]), 8'd1);
        end
        checkOutput("rr_accept_count", 8'(accept_cycles.size() >= 4), 8'd1);
        if (accept_cycles.size() >= 4) begin
            for (int k = 1; k < 4; k++)
                checkOutput($sformatf("rr_gap%0d", k),
                            8'(accept_cycles[k] - accept_cycles[k-1]), 8'd3);
        end

        // Backpressure: result held 5 cycles with both valid, then one accept.
        @(negedge clk);
        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 8'h10; req0_b = 8'h20;
        req1_valid = 1'b1; req1_op = 3'b100; req1_a = 8'h10; req1_b = 8'h20;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("bp_result_seen", 8'(seen), 8'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("bp_hold%0d_valid", i), 8'(res_valid), 8'd1);
            checkOutput($sformatf("bp_hold%0d_out", i), res_out, 8'h30);
            checkOutput($sformatf("bp_hold%0d_id", i), 8'(res_id), 8'd0);
            checkOutput($sformatf("bp_hold%0d_flags", i), {6'd0, res_carry, res_zero}, 8'd0);
            checkOutput($sformatf("bp_hold%0d_ready", i), {6'd0, req0_ready, req1_ready}, 8'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checkOutput("bp_regrant", {6'd0, req0_ready, req1_ready}, 8'b01);
        accepts = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            if (req0_ready || req1_ready) accepts++;
        end
        checkOutput("bp_accepts", 8'(accepts), 8'd1);
        checkOutput("bp_second_out", res_out, 8'hF0);
        checkOutput("bp_second_id", 8'(res_id), 8'd1);
        checkOutput("bp_second_carry", 8'(res_carry), 8'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Reset during EXEC of a req1 XOR after req0 was served last.
        runVector(vecs[0], 100);
        applyStimulus(1'b1, 3'b010, 8'hFF, 8'h0F, acc);
        if (acc) begin
            @(posedge clk);
            @(negedge clk);
            req1_valid = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            checkOutput("mr_valid", 8'(res_valid), 8'd0);
            checkOutput("mr_out", res_out, 8'h00);
            checkOutput("mr_id", 8'(res_id), 8'd0);
            checkOutput("mr_flags", {6'd0, res_carry, res_zero}, 8'd0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1;
                checkOutput($sformatf("mr_no_result%0d", i), 8'(res_valid), 8'd0);
            end
            @(negedge clk);
            req0_valid = 1'b1; req0_op = 3'b000; req0_a = 8'h01; req0_b = 8'h01;
            req1_valid = 1'b1; req1_op = 3'b000; req1_a = 8'h02; req1_b = 8'h02;
            #1;
            checkOutput("mr_first_grant", {6'd0, req0_ready, req1_ready}, 8'b10);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
